rf_wport_arbiter: RTL and testbench
===================================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the single write port of RegisterFile between NR_REQ writeback requesters (ALU, LSU, CSR).
//  - Round-robin arbitration; at most one write granted per cycle.
//  - Registered write stage, one cycle of latency, drives RegisterFile wen/waddr/wdata.
//  - Sits between the execute/memory stages and the register file.
// PARAMETERS
//  NR_REQ      2   number of requesters, 1..8
//  ADDR_WIDTH  5   register address width
//  DATA_WIDTH  32  register data width
//  ZERO_REG    1   1: accepted writes to address 0 are consumed, wen stays 0
// PORTS
//  clk        in   1                    single clock, rising edge
//  rst        in   1                    synchronous, active-high reset
//  req_valid  in   NR_REQ               requester i has a write pending
//  req_addr   in   NR_REQ*ADDR_WIDTH    slice i = [ADDR_WIDTH*(i+1)-1 : ADDR_WIDTH*i]
//  req_data   in   NR_REQ*DATA_WIDTH    slice i = [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//  req_ready  out  NR_REQ               one-hot grant; transfer when valid&ready
//  wb_stall   in   1                    write port unavailable this cycle
//  rf_wen     out  1                    to RegisterFile wen
//  rf_waddr   out  ADDR_WIDTH           to RegisterFile waddr
//  rf_wdata   out  DATA_WIDTH           to RegisterFile wdata
//  wr_count   out  16                   committed writes with rf_wen=1, wraps at 2^16
// BEHAVIOUR
//  - Reset: rf_wen=0, rf_waddr=0, rf_wdata=0, wr_count=0, RR pointer=0.
//    req_ready is combinational and is 0 during any cycle with rst=1.
//  - Grant: req_ready is combinational from req_valid, the pointer and wb_stall.
//    - wb_stall=1: req_ready=0.
//    - Otherwise grant the first valid index at or after ptr, wrapping modulo NR_REQ.
//    - At most one bit of req_ready is set. req_ready never asserts without the matching req_valid.
//  - Handshake: a requester holds valid/addr/data stable until it sees ready.
//    valid may only drop after its transfer completes.
//  - Pointer: after a transfer from index g, ptr <= (g+1) mod NR_REQ.
//    No transfer: ptr holds.
//  - Write stage, registered at the posedge after a transfer from g:
//    - rf_waddr <= addr[g], rf_wdata <= data[g].
//    - rf_wen <= !(ZERO_REG && addr[g]==0).
//    - No transfer: rf_wen <= 0; addr and data hold their last values.
//    - rf_wen is a single-cycle pulse per accepted write.
//  - Latency: transfer in cycle N gives rf_wen=1 in cycle N+1; RegisterFile updates at the end of N+1.
//  - Throughput: 1 write/cycle; back-to-back grants to different requesters are allowed.
//  - wr_count += 1 on each cycle with rf_wen=1; 16'hFFFF -> 0.
//  - Same address from two requesters in the same cycle: serialized in grant order; the last one wins.
//  - Reset asserted mid-stream: the in-flight rf_wen is cleared at that edge and the write is lost.
//    Requesters must re-present their writes after reset.
//  - wb_stall asserted while rf_wen=1: the write in flight still completes.
//    Stall only blocks new grants.
// STRUCTURE
//  - Shared header rf_defs.vh: `RF_ADDR_W 5, `RF_DATA_W 32, `RF_ZERO_ADDR 0.
//  - Sub-module rr_arbiter #(N): combinational.
//    - Inputs: req[N], ptr[$clog2(N)], en.
//    - Outputs: gnt[N] one-hot, gnt_idx, any.
//    - Implementation: double-width rotate and priority-find.
//  - Top holds ptr, the write-stage registers (Reg template, RESET_VAL 0) and wr_count.
//    Data selection uses one-hot AND-OR.
// TESTING
//  1 Reset: rst=1 for 2 cycles with req_valid=2'b11 -> req_ready=0, rf_wen=0, wr_count=0.
//  2 Single: req0 addr=5 data=32'hDEAD_BEEF for 1 cycle
//    -> ready0=1 same cycle; next cycle rf_wen=1, waddr=5, wdata=DEADBEEF; then rf_wen=0.
//  3 Fairness: both valid continuously, addr0=1, addr1=2
//    -> grants 0,1,0,1...; rf_waddr 1,2,1,2; wr_count=4 after 4 writes.
//  4 Zero reg: req1 addr=0 data=7 -> ready1=1, next cycle rf_wen=0, wr_count unchanged.
//    Repeat with ZERO_REG=0 -> rf_wen=1.
//  5 Stall: wb_stall=1 for 3 cycles with req0 valid -> ready0=0 for 3 cycles.
//    After release: granted next cycle, data unchanged, ptr not advanced during the stall.
//  6 Reset mid-op: rst=1 in the cycle after a grant -> rf_wen=0 on the next edge, ptr=0.
//    Also check: wr_count 16'hFFFF + 1 write -> 0.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
// Holds the default register-file geometry, the address treated as the hard-wired
// zero register, and a helper that sizes index signals safely for N=1.
package rf_wport_arbiter_pkg;

  localparam int RF_ADDR_W    = 5;
  localparam int RF_DATA_W    = 32;
  localparam int RF_ZERO_ADDR = 0;
  localparam int WR_COUNT_W   = 16;

  // $clog2(1) is 0, which would give a zero-width index; keep at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wport_arbiter_arb.sv
// Purpose: combinational round-robin arbiter, first request at or after ptr wins.
// Ports: req (request vector), ptr (search start), en (grant enable),
//        gnt (one-hot grant), gnt_idx (binary index of gnt), any (a grant was made).
module rr_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             idx_sum;

  always_comb begin
    // Rotating the doubled vector right by ptr puts index ptr at bit 0, so a
    // plain lowest-bit-first search yields the round-robin winner.
    dbl     = {req, req} >> ptr;
    rot     = dbl[N-1:0];
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx_sum = 0;
    for (int i = 0; i < N; i++) begin
      if (en && rot[i] && !any) begin
        any     = 1'b1;
        idx_sum = int'(ptr) + i;
        if (idx_sum >= N) idx_sum = idx_sum - N;
        gnt_idx = IW'(idx_sum);
        gnt[idx_sum] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Purpose: shares the register-file write port between NR_REQ writeback requesters.
// Ports: clk/rst, req_valid/req_addr/req_data in, req_ready (one-hot grant) out,
//        wb_stall in, rf_wen/rf_waddr/rf_wdata to the register file, wr_count out.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int NR_REQ     = 2,
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_REQ-1:0]            req_valid,
  input  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NR_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic                         wb_stall,
  output logic                         rf_wen,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  output logic [WR_COUNT_W-1:0]        wr_count
);

  localparam int IW = idx_width(NR_REQ);

  logic [IW-1:0]         ptr;
  logic [IW-1:0]         ptr_nxt;
  logic [NR_REQ-1:0]     gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_is_zero;

  // Grants are suppressed during reset so nothing is accepted and then dropped.
  rr_arbiter #(.N(NR_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (!rst && !wb_stall),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign req_ready = gnt;

  // gnt is one-hot (or zero), so AND-OR selection needs no priority mux.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      sel_addr = sel_addr | ({ADDR_WIDTH{gnt[i]}} & req_addr[ADDR_WIDTH*i +: ADDR_WIDTH]);
      sel_data = sel_data | ({DATA_WIDTH{gnt[i]}} & req_data[DATA_WIDTH*i +: DATA_WIDTH]);
    end
  end

  assign ptr_nxt     = (gnt_idx == IW'(NR_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign sel_is_zero = (ZERO_REG != 0) && (sel_addr == ADDR_WIDTH'(RF_ZERO_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wr_count <= '0;
    end else begin
      if (any) begin
        ptr      <= ptr_nxt;
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
        // A write to the zero register is consumed but never reaches the file.
        rf_wen   <= !sel_is_zero;
      end else begin
        rf_wen   <= 1'b0;
      end
      // Counts the write currently presented to the register file; wraps naturally.
      wr_count <= wr_count + {{(WR_COUNT_W-1){1'b0}}, rf_wen};
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: scoreboard of expected write-stage outputs.
// Transfers predicted by a reference grant model are queued and compared one cycle later.
// A second instance with ZERO_REG=0 checks that zero-address writes then reach the file.
module tb_rf_wport_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          wb_stall;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [15:0]   wr_count;

  logic [N-1:0]  nz_ready;
  logic          nz_wen;
  logic [AW-1:0] nz_waddr;
  logic [DW-1:0] nz_wdata;
  logic [15:0]   nz_count;

  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  rf_wport_arbiter #(.NR_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wb_stall(wb_stall), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .wr_count(wr_count)
  );

  rf_wport_arbiter #(.NR_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG(0)) u_nz (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(nz_ready), .wb_stall(wb_stall), .rf_wen(nz_wen), .rf_waddr(nz_waddr),
    .rf_wdata(nz_wdata), .wr_count(nz_count)
  );

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            mptr   = 0;
  logic [15:0]   mcount = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]  rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven; sample at negedge, then advance
  // to just after the next posedge so the caller can drive the next cycle.
  task automatic cycle(input bit chk_out, output logic [N-1:0] seen);
    exp_t         e;
    logic         wen_now;
    logic [N-1:0] er;
    int           g;
    int           idx;
    @(negedge clk);
    wen_now = 1'b0;
    if (q.size() > 0) begin
      e       = q.pop_front();
      m_addr  = e.addr;
      m_data  = e.data;
      wen_now = e.wen;
    end
    if (chk_out) begin
      chk("rf_wen",   64'(rf_wen),   64'(wen_now));
      chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
      chk("wr_count", 64'(wr_count), 64'(mcount));
    end
    if (wen_now) mcount = mcount + 16'd1;
    er = '0;
    g  = 0;
    if (!rst && !wb_stall) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (req_valid[idx] && er == '0) begin
          er[idx] = 1'b1;
          g       = idx;
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    if (er != '0) begin
      e.wen  = (a[g] != '0);
      e.addr = a[g];
      e.data = d[g];
      q.push_back(e);
      mptr = (g + 1) % N;
    end
    if (rst) begin
      q.delete();
      e = '0;
      q.push_back(e);
      mptr   = 0;
      mcount = '0;
    end
    seen = er;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_stall = 1'b0; req_valid = 2'b11;
    a[0] = 5'd1; a[1] = 5'd2; d[0] = 32'h0; d[1] = 32'h0;
    #1;

    // Reset held two cycles with both requesters valid: no grants, outputs cleared.
    cycle(1'b0, rdy);
    cycle(1'b1, rdy);
    rst = 1'b0; req_valid = 2'b00;
    cycle(1'b1, rdy);

    // Single write from requester 0.
    req_valid = 2'b01; a[0] = 5'd5; d[0] = 32'hDEAD_BEEF;
    cycle(1'b1, rdy);
    req_valid = 2'b00;
    cycle(1'b1, rdy);
    cycle(1'b1, rdy);

    // Both requesters continuously valid: grants alternate.
    req_valid = 2'b11; a[0] = 5'd1; a[1] = 5'd2; d[0] = 32'h1000; d[1] = 32'h2000;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, rdy);
      for (int i = 0; i < N; i++) if (rdy[i]) d[i] = d[i] + 32'd1;
    end
    req_valid = 2'b00;
    cycle(1'b1, rdy);
    cycle(1'b1, rdy);

    // Write to address 0 from requester 1.
    req_valid = 2'b10; a[1] = 5'd0; d[1] = 32'd7;
    cycle(1'b1, rdy);
    req_valid = 2'b00;
    #2;
    chk("nz_wen", 64'(nz_wen), 64'd1);
    cycle(1'b1, rdy);
    cycle(1'b1, rdy);

    // Stall for three cycles with requester 0 pending, then release.
    req_valid = 2'b01; a[0] = 5'd9; d[0] = 32'hA5A5_5A5A; wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) cycle(1'b1, rdy);
    chk("ptr_stall", 64'(u_dut.ptr), 64'(mptr));
    wb_stall = 1'b0;
    cycle(1'b1, rdy);
    req_valid = 2'b00;
    cycle(1'b1, rdy);
    cycle(1'b1, rdy);

    // Reset in the cycle after a grant.
    req_valid = 2'b01; a[0] = 5'd3; d[0] = 32'h1234;
    cycle(1'b1, rdy);
    req_valid = 2'b00; rst = 1'b1;
    cycle(1'b1, rdy);
    rst = 1'b0;
    #2;
    chk("ptr_rst", 64'(u_dut.ptr), 64'(mptr));
    cycle(1'b1, rdy);

    // Continuous writes long enough for wr_count to pass 16'hFFFF and wrap.
    req_valid = 2'b11; a[0] = 5'd1; a[1] = 5'd2;
    for (int c = 0; c < 65540; c++) begin
      cycle(1'b1, rdy);
      for (int i = 0; i < N; i++) if (rdy[i]) d[i] = d[i] + 32'd1;
    end
    req_valid = 2'b00;
    cycle(1'b1, rdy);
    cycle(1'b1, rdy);
    chk("wr_count_final", 64'(wr_count), 64'(mcount));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
